instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  Initiator side of the instruction-memory read interface: owns the PC, drives the word-aligned
//  fetch address, takes the combinational instruction word back, and registers it into the IF/ID
//  pipeline register for decode.
//  Sits between the hazard/branch logic (EXE stage) and the ID stage of the 5-stage ARM pipeline.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  bubble word placed in IF/ID on reset/flush
// PORTS
//  clk             in   1   pipeline clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  freeze          in   1   hazard-unit stall: hold PC and IF/ID
//  branch_taken    in   1   EXE-stage redirect; also flushes IF/ID
//  branch_addr     in   32  redirect target (bits[1:0] ignored)
//  imem_addr       out  32  fetch address to instruction memory, always {pc[31:2],2'b00}
//  imem_rdata      in   32  instruction word for imem_addr, valid same cycle (combinational memory)
//  if_pc           out  32  registered PC+4 of the fetched instruction (to ID)
//  if_instruction  out  32  registered instruction (to ID)
//  if_valid        out  1   IF/ID holds a real instruction (0 = bubble)
//  fetch_count     out  32  [IFETCH_PERF_CNT_EN only] instructions accepted into IF/ID
//  stall_count     out  32  [IFETCH_PERF_CNT_EN only] cycles with freeze=1 and branch_taken=0
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-stall):
//      pc = RESET_PC; if_pc = 0; if_instruction = NOP_INSTR; if_valid = 0; counters = 0.
//  - imem_addr is combinational from pc; low two bits always 0.
//  - Each rising edge, priority order:
//      1) branch_taken: pc <= {branch_addr[31:2],2'b00}; IF/ID <= {0, NOP_INSTR, valid 0}
//         (flush; overrides freeze)
//      2) freeze: pc, if_pc, if_instruction, if_valid all hold
//      3) else: pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0);
//         if_pc <= pc+4; if_instruction <= imem_rdata; if_valid <= 1
//  - Latency: the word at address A appears on if_instruction one edge after imem_addr==A
//    with freeze=0 and branch_taken=0.
//  - First cycle after reset: imem_addr = RESET_PC; if_valid rises at the first unfrozen edge.
//  - Back-to-back branches: each one redirects; the last one wins; IF/ID stays a bubble throughout.
//  - freeze held N cycles: IF/ID and imem_addr stay constant for N cycles, no instruction lost.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined:
//    - fetch_count and stall_count ports exist.
//    - fetch_count increments on every case-3 edge.
//    - stall_count increments on every case-2 edge.
//    - Both wrap mod 2^32; both reset to 0.
//  Not defined: both ports and their registers are absent; the rest of the behaviour is unchanged.
// STRUCTURE
//  - ifetch_pkg holds:
//      INSTR_W = 32, ADDR_W = 32, PC_STEP = 4
//      the default NOP_INSTR
//      typedef if_id_t {pc, instruction, valid}
//  - One sub-module, pc_register:
//      clk, rst, load enable, next-PC input, RESET_PC parameter
//      instantiated once
//  - IF/ID register, next-PC mux and counters stay in this module.
// TESTING
//  - Reset then 4 free-running cycles with mem[0..15] = 0xE3A00001, 0xE3A01002, ...
//      -> imem_addr 0, 4, 8, C
//      -> if_pc 4, 8, C
//      -> if_instruction follows one cycle behind
//  - freeze=1 for 3 cycles at pc=0x8
//      -> imem_addr stays 0x8 and IF/ID stays unchanged for 3 cycles
//      -> on release, if_pc = 0xC
//      -> stall_count = 3 when IFETCH_PERF_CNT_EN is defined
//  - branch_taken=1 with branch_addr=0x102 and freeze=1 in the same cycle
//      -> next imem_addr = 0x100, if_valid = 0, if_instruction = NOP_INSTR
//      -> following cycle if_pc = 0x104
//  - Branch to 0xFFFF_FFFC, then run 2 cycles
//      -> imem_addr 0xFFFF_FFFC, then 0x0
//      -> if_pc = 0x0 for the wrapped fetch
//  - Assert rst asynchronously mid-freeze at pc=0x20
//      -> outputs go to reset values immediately, before the next clk edge
//      -> after deassert, imem_addr = RESET_PC
//  - Build without IFETCH_PERF_CNT_EN
//      -> elaborates with no counter ports
//      -> scenario 1 trace is identical

Source files
------------

// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
//   Shared widths, constants and the IF/ID pipeline-register layout for the
//   instruction fetch stage.
//   Contents:
//     INSTR_W, ADDR_W    instruction and address widths (32)
//     PC_STEP            byte distance between sequential instructions (4)
//     DEFAULT_NOP_INSTR  default bubble word for IF/ID
//     if_id_t            IF/ID register {pc, instruction, valid}
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP           = 32'd4;
    localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;           // PC+4 of the fetched instruction
        logic [INSTR_W-1:0] instruction;
        logic               valid;        // 0 = bubble
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// ----------------------------------------------------------------------------
// pc_register
//   Program counter storage. Loads pc_d when load_en is high, otherwise holds.
//   The reset value is word-aligned so the PC is always a word address.
//   Ports:
//     clk      in   pipeline clock, rising edge
//     rst      in   asynchronous, active-high reset
//     load_en  in   1 = take pc_d this edge
//     pc_d     in   next PC (already word-aligned by the caller)
//     pc_q     out  current PC
//   Parameters:
//     RESET_PC      PC value loaded on reset
// ----------------------------------------------------------------------------
module pc_register
    import ifetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] pc_d,
    output logic [ADDR_W-1:0] pc_q
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; reset is in the sensitivity list so it
    // takes effect immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
        end else if (load_en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//   IF stage of the 5-stage pipeline: owns the PC, presents a word-aligned
//   fetch address to a combinational instruction memory and registers the
//   returned word into the IF/ID pipeline register.
//   Edge priority: branch_taken (redirect + flush) > freeze (hold) > advance.
//   Ports:
//     clk             in   pipeline clock, rising edge
//     rst             in   asynchronous, active-high reset
//     freeze          in   hazard stall: hold PC and IF/ID
//     branch_taken    in   EXE redirect; flushes IF/ID
//     branch_addr     in   redirect target (bits [1:0] ignored)
//     imem_addr       out  fetch address, always word-aligned
//     imem_rdata      in   instruction word for imem_addr, same cycle
//     if_pc           out  PC+4 of the instruction in IF/ID
//     if_instruction  out  instruction in IF/ID
//     if_valid        out  IF/ID holds a real instruction
//     fetch_count     out  instructions accepted into IF/ID  (IFETCH_PERF_CNT_EN)
//     stall_count     out  frozen, non-branch cycles         (IFETCH_PERF_CNT_EN)
//   Build option:
//     IFETCH_PERF_CNT_EN  adds the two 32-bit wrapping performance counters.
// ----------------------------------------------------------------------------
module instruction_fetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instruction,
    output logic               if_valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pc_load;
    logic              advance;
    logic              branch_addr_unused;
    if_id_t            if_id_q;
    if_id_t            if_id_d;

    // Targets are forced to a word boundary, so the low bits are never used.
    assign branch_addr_unused = ^branch_addr[1:0];

    // Sequential fetch step; wraps naturally at 2^32.
    assign pc_plus4 = pc_q + PC_STEP;
    assign advance  = ~branch_taken & ~freeze;
    assign pc_load  = branch_taken | ~freeze;
    assign pc_d     = branch_taken ? {branch_addr[ADDR_W-1:2], 2'b00} : pc_plus4;

    // PC is only ever loaded with aligned values, so it drives memory directly.
    assign imem_addr = pc_q;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .pc_d    (pc_d),
        .pc_q    (pc_q)
    );

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        if_id_d = if_id_q;
        if (branch_taken) begin
            if_id_d = '{pc: '0, instruction: NOP_INSTR, valid: 1'b0};
        end else if (!freeze) begin
            if_id_d = '{pc: pc_plus4, instruction: imem_rdata, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= '{pc: '0, instruction: NOP_INSTR, valid: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_pc          = if_id_q.pc;
    assign if_instruction = if_id_q.instruction;
    assign if_valid       = if_id_q.valid;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (advance) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (freeze && !branch_taken) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic advance_unused;
    assign advance_unused = advance;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//   Directed bench for instruction_fetch_stage. The bench supplies a small
//   combinational instruction memory, keeps a behavioural model of the stage
//   that is compared against the DUT every cycle, and pins that model with
//   hand-computed literal expectations at key points.
//   Build option: IFETCH_PERF_CNT_EN also checks the performance counters.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    instruction_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: low 16 words follow the ARM MOV pattern, everything
    // else is an address-derived tag so any wrong fetch is visible.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (addr < 32'd64)
            return 32'hE3A0_0000 | (idx << 12) | (idx + 32'd1);
        return {addr[31:16] ^ 16'hC0DE, addr[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_if_pc, m_instr, m_fetch, m_stall;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= RESET_PC & ~32'd3;
            m_if_pc <= 32'd0;
            m_instr <= NOP_INSTR;
            m_valid <= 1'b0;
            m_fetch <= 32'd0;
            m_stall <= 32'd0;
        end else if (branch_taken) begin
            m_pc    <= branch_addr & ~32'd3;
            m_if_pc <= 32'd0;
            m_instr <= NOP_INSTR;
            m_valid <= 1'b0;
        end else if (freeze) begin
            m_stall <= m_stall + 32'd1;
        end else begin
            m_instr <= mem_word(m_pc);
            m_pc    <= m_pc + 32'd4;
            m_if_pc <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_fetch <= m_fetch + 32'd1;
        end
    end

    // Compare process: 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (cmp_en && !rst) begin
            check("model_imem_addr", imem_addr, m_pc);
            check("model_if_pc", if_pc, m_if_pc);
            check("model_if_instruction", if_instruction, m_instr);
            check("model_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
`ifdef IFETCH_PERF_CNT_EN
            check("model_fetch_count", fetch_count, m_fetch);
            check("model_stall_count", stall_count, m_stall);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one edge and land 3 units after it (after the compare).
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instruction", if_instruction, NOP_INSTR);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic pin_if(input string tag, input logic [31:0] addr,
                          input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid);
        check({tag, "_imem_addr"}, imem_addr, addr);
        check({tag, "_if_pc"}, if_pc, pc);
        check({tag, "_if_instruction"}, if_instruction, instr);
        check({tag, "_if_valid"}, {31'd0, if_valid}, {31'd0, valid});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        #2;
        do_reset();
        cmp_en = 1'b1;

        // Scenario 1: free run from reset.
        tick();
        pin_if("run1", 32'h4, 32'h4, 32'hE3A0_0001, 1'b1);
        tick();
        pin_if("run2", 32'h8, 32'h8, 32'hE3A0_1002, 1'b1);
        tick();
        pin_if("run3", 32'hC, 32'hC, 32'hE3A0_2003, 1'b1);

        // Scenario 2: freeze for 3 edges with pc = 0x8.
        do_reset();
        ticks(2);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pin_if("frz", 32'h8, 32'h8, 32'hE3A0_1002, 1'b1);
        end
`ifdef IFETCH_PERF_CNT_EN
        check("frz_stall_count", stall_count, 32'd3);
        check("frz_fetch_count", fetch_count, 32'd2);
`endif
        freeze = 1'b0;
        tick();
        pin_if("rel", 32'hC, 32'hC, 32'hE3A0_2003, 1'b1);

        // Scenario 3: branch overrides freeze in the same cycle.
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h102;
        tick();
        pin_if("brfrz", 32'h100, 32'h0, NOP_INSTR, 1'b0);
        freeze       = 1'b0;
        branch_taken = 1'b0;
        tick();
        pin_if("brnext", 32'h104, 32'h104, 32'hC0DE_0100, 1'b1);

        // Back-to-back branches: last one wins, IF/ID stays a bubble.
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        tick();
        pin_if("bb1", 32'h200, 32'h0, NOP_INSTR, 1'b0);
        branch_addr  = 32'h303;
        tick();
        pin_if("bb2", 32'h300, 32'h0, NOP_INSTR, 1'b0);
        branch_taken = 1'b0;
        tick();
        pin_if("bb3", 32'h304, 32'h304, 32'hC0DE_0300, 1'b1);

        // Scenario 4: PC wrap at the top of the address space.
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFE;
        tick();
        pin_if("wrap0", 32'hFFFF_FFFC, 32'h0, NOP_INSTR, 1'b0);
        branch_taken = 1'b0;
        tick();
        pin_if("wrap1", 32'h0, 32'h0, 32'h3F21_FFFC, 1'b1);
        tick();
        pin_if("wrap2", 32'h4, 32'h4, 32'hE3A0_0001, 1'b1);

        // Scenario 5: asynchronous reset mid-freeze at pc = 0x20.
        do_reset();
        ticks(8);
        check("pre_async_imem_addr", imem_addr, 32'h20);
        freeze = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        pin_if("async", RESET_PC, 32'h0, NOP_INSTR, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
        check("async_fetch_count", fetch_count, 32'd0);
        check("async_stall_count", stall_count, 32'd0);
`endif
        tick();
        rst    = 1'b0;
        freeze = 1'b0;
        #1;
        check("post_async_imem_addr", imem_addr, RESET_PC);
        tick();
        pin_if("post_async", 32'h4, 32'h4, 32'hE3A0_0001, 1'b1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
